mips_port_uart_tx: RTL and testbench

Memory-mapped serial output port downstream of the MIPS processor core's MEM stage. Captures byte stores aimed at the output port into a small FIFO and serializes them as 8N1 UART frames on `tx`. Returns an 8-bit status word that feeds the processor's `PortIn`, so software can poll before writing.

---
 rtl/mips_port_uart_tx.sv | 189 ++++++++++++++++++
 tb/tb_mips_port_uart_tx.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mips_port_uart_tx.sv
// Memory-mapped UART transmit port: byte FIFO feeding an 8N1 serializer with a polled status word.
// Define UART_TX_PARITY_EN to build 8E1 frames (adds an even-parity bit before the stop bit).
module mips_port_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          ovf_clr,
  output logic                          tx,
  output logic [7:0]                    port_status,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_e;

  state_e          state_q;
  logic [7:0]      shift_q;
  logic [TW-1:0]   tmr_q;
  logic [2:0]      bit_idx_q;
  logic            tx_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            ovf_q;
  logic            ovf_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

`ifdef UART_TX_PARITY_EN
  logic            parity_q;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`endif

  logic empty_s;
  logic full_s;
  logic busy_s;
  logic pop_s;
  logic accept_s;
  logic ovf_set_s;

  assign empty_s   = (count_q == {CW{1'b0}});
  assign full_s    = (count_q == FULL_CNT);
  assign busy_s    = (state_q != S_IDLE);
  assign pop_s     = (state_q == S_IDLE) && !empty_s;
  assign accept_s  = wr_en && (!full_s || pop_s);
  assign ovf_set_s = wr_en && full_s && !pop_s;

  // A write that races a pop into a full FIFO leaves occupancy unchanged.
  always_comb begin
    count_d = count_q;
    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      if (accept_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)    rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (accept_s) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= 8'h00;
      tmr_q     <= {TW{1'b0}};
      bit_idx_q <= 3'd0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop_s) begin
            shift_q <= mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            parity_q <= even_parity(mem_q[rd_ptr_q]);
`endif
            tmr_q   <= BIT_LAST;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (tmr_q == {TW{1'b0}}) begin
            tmr_q     <= BIT_LAST;
            bit_idx_q <= 3'd0;
            tx_q      <= shift_q[0];
            state_q   <= S_DATA;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        S_DATA: begin
          if (tmr_q == {TW{1'b0}}) begin
            tmr_q <= BIT_LAST;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (tmr_q == {TW{1'b0}}) begin
            tmr_q   <= BIT_LAST;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
`endif
        S_STOP: begin
          tx_q <= 1'b1;
          if (tmr_q == {TW{1'b0}}) begin
            state_q <= S_IDLE;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx          = tx_q;
  assign port_status = {4'b0000, ovf_q, busy_s, full_s, empty_s};
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_mips_port_uart_tx.sv
// Random and directed bench for mips_port_uart_tx; a frame-level queue model predicts tx and status every cycle.
module tb_mips_port_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       ovf_clr;
  logic       tx;
  logic [7:0] port_status;
  logic [3:0] fifo_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: byte queue plus a countdown of cycles left in the current frame.
  logic [7:0] m_q[$];
  int         m_busy_left;
  logic [7:0] m_byte;
  logic       m_ovf;

  mips_port_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .ovf_clr(ovf_clr),
    .tx(tx), .port_status(port_status), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_tx();
    int idx;
    if (m_busy_left == 0) return 1'b1;
    idx = (FRAME - m_busy_left) / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_byte[idx-1];
    if (NBITS == 11 && idx == 9) return ^m_byte;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_busy_left = 0;
    m_byte      = 8'h00;
    m_ovf       = 1'b0;
  endtask

  task automatic model_edge(input logic w, input logic [7:0] d, input logic c);
    logic pop;
    logic full;
    pop  = (m_busy_left == 0) && (m_q.size() > 0);
    full = (m_q.size() == DEPTH);
    if (pop) begin
      m_byte      = m_q.pop_front();
      m_busy_left = FRAME;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
    end
    if (w && (!full || pop)) m_q.push_back(d);
    if (w && full && !pop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
  endtask

  task automatic check_outputs();
    logic [7:0] st;
    st = {4'b0000, m_ovf, (m_busy_left != 0), (m_q.size() == DEPTH), (m_q.size() == 0)};
    check_eq("tx", 32'(tx), 32'(exp_tx()));
    check_eq("port_status", 32'(port_status), 32'(st));
    check_eq("fifo_count", 32'(fifo_count), 32'(m_q.size()));
  endtask

  task automatic cycle(input logic w, input logic [7:0] d, input logic c);
    wr_en   = w;
    wr_data = d;
    ovf_clr = c;
    @(posedge clk);
    model_edge(w, d, c);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
  endtask

  // Asserted mid-cycle so the asynchronous response is visible before any clock edge.
  task automatic do_reset();
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    reset   = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b0;
  endtask

  initial begin
    int pct;
    int guard;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    ovf_clr = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    cycle(1'b1, 8'hA5, 1'b0);
    idle(FRAME + 5);

    for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom), 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    guard = 0;
    while (m_busy_left != 0 && guard < 2 * FRAME) begin
      cycle(1'b0, 8'h00, 1'b0);
      guard++;
    end
    check_eq("pop_wait_bound", 32'(guard < 2 * FRAME), 32'd1);
    cycle(1'b1, 8'h3C, 1'b0);
    idle(10 * (FRAME + 1) + 5);

    cycle(1'b1, 8'h55, 1'b0);
    cycle(1'b1, 8'h0F, 1'b0);
    idle(2 * (FRAME + 1) + 4);

    cycle(1'b1, 8'h07, 1'b0);
    idle(FRAME + 4);

    cycle(1'b1, 8'hC3, 1'b0);
    cycle(1'b1, 8'h81, 1'b0);
    idle(1 + 4 * CPB + 2);
    do_reset();
    idle(FRAME + 10);

    pct = 30;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) pct = (i / 500) % 3 == 0 ? 5 : ((i / 500) % 3 == 1 ? 90 : 30);
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 99) < pct, 8'($urandom), $urandom_range(0, 63) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
